// File: rtl/ps2_event_queue.sv
// ps2_event_queue
// Keyboard front end between the PS/2 interface and the processor.
// Decodes the set-2 scan-code prefixes E0 (extended) and F0 (release) and
// pushes each complete key event into a show-ahead FIFO that the processor
// drains with a pop handshake.
//
// Ports
//   clock           processor clock, all logic synchronous to it
//   reset           synchronous active-high reset
//   ps2_key_pressed byte-available strobe; only its rising edge counts
//   ps2_key_data    scan-code byte, valid in the rising-edge cycle
//   pop             consumer acknowledges the head entry
//   clear_overflow  clears the sticky overflow flag
//   evt_valid       FIFO non-empty
//   evt_data        head entry {extended, release, code[7:0]}, 0 when empty
//   count           occupied entries, 0..DEPTH
//   overflow        sticky, at least one event was dropped
module ps2_event_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_key_data,
  input  logic              pop,
  input  logic              clear_overflow,
  output logic              evt_valid,
  output logic [9:0]        evt_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0
  } decodeState_t;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      PrefixExt = 8'hE0;
  localparam logic [7:0]      PrefixRel = 8'hF0;

  decodeState_t        state_q, state_d;
  logic                prevPressed_q;
  logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [9:0]          mem [DEPTH];

  logic                byteStb;
  logic                push;
  logic [9:0]          pushData;
  logic                full;
  logic                popEff;
  logic                pushEff;
  logic                drop;

  // A held strobe must produce a single byte, so only the 0->1 transition
  // of ps2_key_pressed is treated as a new byte.
  assign byteStb = ps2_key_pressed & ~prevPressed_q;

  // Prefix decoder: prefixes only move the state, any other byte completes
  // an event carrying the pending extended/release flags.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pushData = '0;
    if (byteStb) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_key_data == PrefixExt)      state_d = StE0;
          else if (ps2_key_data == PrefixRel) state_d = StF0;
          else begin
            push     = 1'b1;
            pushData = {2'b00, ps2_key_data};
          end
        end
        StE0: begin
          if (ps2_key_data == PrefixRel)      state_d = StE0F0;
          else if (ps2_key_data == PrefixExt) state_d = StE0;
          else begin
            push     = 1'b1;
            pushData = {2'b10, ps2_key_data};
            state_d  = StIdle;
          end
        end
        StF0: begin
          // An E0 after a stray F0 restarts as a plain extended prefix.
          if (ps2_key_data == PrefixExt)      state_d = StE0;
          else if (ps2_key_data == PrefixRel) state_d = StF0;
          else begin
            push     = 1'b1;
            pushData = {2'b01, ps2_key_data};
            state_d  = StIdle;
          end
        end
        StE0F0: begin
          if (ps2_key_data == PrefixExt)      state_d = StE0;
          else if (ps2_key_data == PrefixRel) state_d = StE0F0;
          else begin
            push     = 1'b1;
            pushData = {2'b11, ps2_key_data};
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO control: a pop on a full FIFO frees the slot for a push in the
  // same cycle, so that push is accepted rather than dropped.
  always_comb begin
    full    = (count_q == FullCount);
    popEff  = pop & evt_valid;
    pushEff = push & (~full | popEff);
    drop    = push & full & ~popEff;

    wrPtr_d = pushEff ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = popEff  ? rdPtr_q + 1'b1 : rdPtr_q;

    count_d = count_q;
    if (pushEff && !popEff)      count_d = count_q + 1'b1;
    else if (!pushEff && popEff) count_d = count_q - 1'b1;

    // Set beats clear so a drop in the clearing cycle is never lost.
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      prevPressed_q <= 1'b0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prevPressed_q <= ps2_key_pressed;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage is left uninitialised; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (!reset && pushEff) mem[wrPtr_q] <= pushData;
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem[rdPtr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
